// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//
// Hardwired control unit for the single-bus datapath.  Every instruction is
// fetched in three cycles (T0..T2).  An opcode-dependent execute sequence
// follows in T3..T6.  The unit also provides a start/stop run handshake and a
// counter of retired instructions.
//
// Ports
//   clock        system clock, rising-edge active
//   clear        asynchronous active-low reset
//   IR           instruction register contents from the datapath
//   start        resume request; only honoured while halted
//   stop         request a halt once the current instruction has retired
//   run          high while instructions are being sequenced
//   PCout .. LOin  datapath bus / register strobes
//   ALU_MUL      selects the multiplier result path
//   ALU_DIV      selects the divider result path
//   ALUop        ALU function select (opcode[3:0] for reg-reg ALU ops)
//   Rin          one-hot register-file write enable
//   Rout         one-hot register-file output enable
//   illegal      one-cycle pulse in T3 for an undefined opcode
//   instr_count  retired-instruction counter, wraps at 2^CNT_W
//
// Instruction fields: opcode=IR[31:27], Ra=IR[26:23] (destination),
// Rb=IR[22:19], Rc=IR[18:15].
// -----------------------------------------------------------------------------
module control_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [31:0]      IR,
  input  logic             start,
  input  logic             stop,
  output logic             run,
  output logic             PCout,
  output logic             MARin,
  output logic             IncPC,
  output logic             Read,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Yin,
  output logic             Zlowin,
  output logic             Zhighin,
  output logic             Zlowout,
  output logic             Zhighout,
  output logic             HIin,
  output logic             LOin,
  output logic             ALU_MUL,
  output logic             ALU_DIV,
  output logic [3:0]       ALUop,
  output logic [15:0]      Rin,
  output logic [15:0]      Rout,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_T0     = 4'd1,
    S_T1     = 4'd2,
    S_T2     = 4'd3,
    S_T3     = 4'd4,
    S_T4     = 4'd5,
    S_T5     = 4'd6,
    S_T6     = 4'd7,
    S_HALTED = 4'd8
  } state_t;

  localparam logic [4:0] OP_ALU_LAST = 5'h0A;
  localparam logic [4:0] OP_MUL      = 5'h0F;
  localparam logic [4:0] OP_DIV      = 5'h10;
  localparam logic [4:0] OP_NOP      = 5'h1A;
  localparam logic [4:0] OP_HALT     = 5'h1B;

  state_t             state_reg;
  state_t             state_next;
  logic               stop_latch_reg;
  logic               stop_latch_next;
  logic [CNT_W-1:0]   count_reg;
  logic [CNT_W-1:0]   count_next;

  // ---------------------------------------------------------------------------
  // Instruction field decode
  // ---------------------------------------------------------------------------
  logic [4:0]  opcode;
  logic [3:0]  ra;
  logic [3:0]  rb;
  logic [3:0]  rc;
  logic [15:0] ra_onehot;
  logic [15:0] rb_onehot;
  logic [15:0] rc_onehot;
  logic        is_alu;
  logic        is_mul;
  logic        is_div;
  logic        is_muldiv;
  logic        is_nop;
  logic        is_halt;
  logic        is_legal;

  assign opcode = IR[31:27];
  assign ra     = IR[26:23];
  assign rb     = IR[22:19];
  assign rc     = IR[18:15];

  // The low IR bits carry immediates for instruction classes this unit does
  // not sequence; fold them so the input port is fully consumed.
  logic unused_ir_low;
  assign unused_ir_low = ^IR[14:0];

  assign is_alu    = (opcode <= OP_ALU_LAST);
  assign is_mul    = (opcode == OP_MUL);
  assign is_div    = (opcode == OP_DIV);
  assign is_muldiv = is_mul | is_div;
  assign is_nop    = (opcode == OP_NOP);
  assign is_halt   = (opcode == OP_HALT);
  assign is_legal  = is_alu | is_muldiv | is_nop | is_halt;

  // One-hot register selects for the three register fields.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_reg_sel
      assign ra_onehot[gi] = (ra == 4'(gi));
      assign rb_onehot[gi] = (rb == 4'(gi));
      assign rc_onehot[gi] = (rc == 4'(gi));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Retirement and halt decision
  // ---------------------------------------------------------------------------
  logic   in_run_state;
  logic   retire;
  logic   stop_pending;
  state_t after_retire;

  assign in_run_state = (state_reg != S_RESET) && (state_reg != S_HALTED);

  // The cycle in which each instruction class performs its last action.
  assign retire = ((state_reg == S_T3) && (is_nop || is_halt)) ||
                  ((state_reg == S_T5) && is_alu) ||
                  ((state_reg == S_T6) && is_muldiv);

  // A stop that arrives on the retiring edge itself is honoured immediately
  // rather than carrying an extra instruction.
  assign stop_pending = stop_latch_reg | stop;
  assign after_retire = (stop_pending || is_halt) ? S_HALTED : S_T0;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_reg <= S_RESET;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_RESET: state_next = S_T0;
      S_T0:    state_next = S_T1;
      S_T1:    state_next = S_T2;
      S_T2:    state_next = S_T3;
      S_T3: begin
        if (!is_legal) begin
          // Undefined opcodes are dropped without retiring.
          state_next = S_T0;
        end else if (is_nop || is_halt) begin
          state_next = after_retire;
        end else begin
          state_next = S_T4;
        end
      end
      S_T4: state_next = (is_alu || is_muldiv) ? S_T5 : S_T0;
      S_T5: state_next = is_muldiv ? S_T6 : after_retire;
      S_T6: state_next = after_retire;
      S_HALTED: begin
        if (start) begin
          state_next = S_T0;
        end
      end
      default: state_next = S_RESET;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode (pure function of state and IR)
  // ---------------------------------------------------------------------------
  always_comb begin
    run      = in_run_state;
    PCout    = 1'b0;
    MARin    = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zlowin   = 1'b0;
    Zhighin  = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    ALU_MUL  = 1'b0;
    ALU_DIV  = 1'b0;
    ALUop    = 4'd0;
    Rin      = 16'd0;
    Rout     = 16'd0;
    illegal  = 1'b0;
    unique case (state_reg)
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
      end
      S_T1: begin
        Read  = 1'b1;
        MDRin = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        // First operand into Y for anything that uses the ALU.
        if (is_alu || is_muldiv) begin
          Rout = rb_onehot;
          Yin  = 1'b1;
        end else if (!is_legal) begin
          illegal = 1'b1;
        end
      end
      S_T4: begin
        if (is_alu) begin
          Rout   = rc_onehot;
          ALUop  = opcode[3:0];
          Zlowin = 1'b1;
        end else if (is_muldiv) begin
          // Wide results land in both halves of Z.
          Rout    = rc_onehot;
          ALU_MUL = is_mul;
          ALU_DIV = is_div;
          Zlowin  = 1'b1;
          Zhighin = 1'b1;
        end
      end
      S_T5: begin
        if (is_alu) begin
          Zlowout = 1'b1;
          Rin     = ra_onehot;
        end else if (is_muldiv) begin
          Zlowout = 1'b1;
          LOin    = 1'b1;
        end
      end
      S_T6: begin
        if (is_muldiv) begin
          Zhighout = 1'b1;
          HIin     = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stop latch and retired-instruction counter
  // ---------------------------------------------------------------------------
  always_comb begin
    stop_latch_next = stop_latch_reg;
    if (state_next == S_HALTED) begin
      // Halting consumes the request; a start/stop pair while halted
      // therefore resumes with the latch clear.
      stop_latch_next = 1'b0;
    end else if (in_run_state && stop) begin
      stop_latch_next = 1'b1;
    end
  end

  always_comb begin
    count_next = count_reg;
    if (retire) begin
      count_next = count_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      stop_latch_reg <= 1'b0;
      count_reg      <= '0;
    end else begin
      stop_latch_reg <= stop_latch_next;
      count_reg      <= count_next;
    end
  end

  assign instr_count = count_reg;

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
//
// Directed bench for control_sequencer.  A queue-based model builds, per
// instruction, the list of strobe patterns each cycle must show, and a compare
// process checks the DUT against it on every falling clock edge.  Hand-written
// literal checks at key points pin the model itself.  The counter is
// narrowed to 4 bits so that wrap-around can be exercised quickly.
// -----------------------------------------------------------------------------
module tb_control_sequencer;

  localparam int CNT_W = 4;

  logic             clock;
  logic             clear;
  logic [31:0]      IR;
  logic             start;
  logic             stop;
  logic             run;
  logic             PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin;
  logic             Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin;
  logic             ALU_MUL, ALU_DIV;
  logic [3:0]       ALUop;
  logic [15:0]      Rin;
  logic [15:0]      Rout;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;

  control_sequencer #(.CNT_W(CNT_W)) dut (
    .clock(clock), .clear(clear), .IR(IR), .start(start), .stop(stop),
    .run(run), .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
    .Zlowin(Zlowin), .Zhighin(Zhighin), .Zlowout(Zlowout),
    .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin),
    .ALU_MUL(ALU_MUL), .ALU_DIV(ALU_DIV), .ALUop(ALUop),
    .Rin(Rin), .Rout(Rout), .illegal(illegal), .instr_count(instr_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // All strobes of one cycle, excluding run and the counter.
  typedef struct packed {
    logic        illegal;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [3:0]  aluop;
    logic        alu_mul, alu_div;
    logic        pcout, marin, incpc, read, mdrin, mdrout, irin, yin;
    logic        zlowin, zhighin, zlowout, zhighout, hiin, loin;
  } strobes_t;

  strobes_t act;
  assign act = {illegal, Rin, Rout, ALUop, ALU_MUL, ALU_DIV,
                PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin,
                Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin};

  int vectors     = 0;
  int miscompares = 0;

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  typedef enum {M_RESET, M_RUN, M_HALTED} mmode_t;

  mmode_t           m_mode   = M_RESET;
  strobes_t         m_q[$];          // remaining cycles of the current phase
  bit               m_fetched = 1'b0; // execute cycles already queued
  bit               m_retire  = 1'b0; // current instruction retires
  bit               m_halt    = 1'b0; // current instruction is HALT
  bit               m_stop    = 1'b0;
  logic [CNT_W-1:0] m_count   = '0;

  function automatic strobes_t blank();
    strobes_t r;
    r = '0;
    return r;
  endfunction

  task automatic model_start_instr();
    strobes_t r;
    m_q.delete();
    r = blank(); r.pcout = 1'b1; r.marin = 1'b1; r.incpc = 1'b1; m_q.push_back(r);
    r = blank(); r.read = 1'b1; r.mdrin = 1'b1;                  m_q.push_back(r);
    r = blank(); r.mdrout = 1'b1; r.irin = 1'b1;                 m_q.push_back(r);
    m_fetched = 1'b0;
  endtask

  task automatic model_build_exec(input logic [31:0] ir);
    strobes_t r;
    int op, ra, rb, rc;
    op = int'(ir[31:27]);
    ra = int'(ir[26:23]);
    rb = int'(ir[22:19]);
    rc = int'(ir[18:15]);
    m_retire = 1'b1;
    m_halt   = 1'b0;
    if (op <= 10) begin
      r = blank(); r.rout = 16'(1 << rb); r.yin = 1'b1; m_q.push_back(r);
      r = blank(); r.rout = 16'(1 << rc); r.aluop = 4'(op); r.zlowin = 1'b1; m_q.push_back(r);
      r = blank(); r.zlowout = 1'b1; r.rin = 16'(1 << ra); m_q.push_back(r);
    end else if (op == 15 || op == 16) begin
      r = blank(); r.rout = 16'(1 << rb); r.yin = 1'b1; m_q.push_back(r);
      r = blank(); r.rout = 16'(1 << rc); r.zlowin = 1'b1; r.zhighin = 1'b1;
      r.alu_mul = (op == 15); r.alu_div = (op == 16); m_q.push_back(r);
      r = blank(); r.zlowout = 1'b1; r.loin = 1'b1; m_q.push_back(r);
      r = blank(); r.zhighout = 1'b1; r.hiin = 1'b1; m_q.push_back(r);
    end else if (op == 26 || op == 27) begin
      m_q.push_back(blank());
      m_halt = (op == 27);
    end else begin
      r = blank(); r.illegal = 1'b1; m_q.push_back(r);
      m_retire = 1'b0;
    end
  endtask

  task automatic model_step();
    case (m_mode)
      M_RESET: begin
        m_mode = M_RUN;
        model_start_instr();
      end
      M_HALTED: begin
        if (start) begin
          m_mode = M_RUN;
          model_start_instr();
        end
      end
      default: begin
        if (stop) m_stop = 1'b1;
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          if (!m_fetched) begin
            model_build_exec(IR);
            m_fetched = 1'b1;
          end else begin
            if (m_retire) m_count = m_count + 1'b1;
            if (m_retire && (m_stop || m_halt)) begin
              m_mode = M_HALTED;
              m_stop = 1'b0;
            end else begin
              model_start_instr();
            end
          end
        end
      end
    endcase
  endtask

  initial begin
    forever begin
      @(posedge clock or negedge clear);
      if (!clear) begin
        m_mode  = M_RESET;
        m_count = '0;
        m_stop  = 1'b0;
        m_q.delete();
      end else begin
        model_step();
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare against the model
  // ---------------------------------------------------------------------------
  initial begin
    strobes_t exp_s;
    logic     exp_run;
    forever begin
      @(negedge clock);
      if (m_mode == M_RUN && m_q.size() > 0) begin
        exp_s   = m_q[0];
        exp_run = 1'b1;
      end else begin
        exp_s   = '0;
        exp_run = 1'b0;
      end
      vectors++;
      if (act !== exp_s || run !== exp_run || instr_count !== m_count) begin
        miscompares++;
        $display("FAIL cycle_check t=%0t: strobes got %h exp %h, run got %b exp %b, count got %0d exp %0d",
                 $time, act, exp_s, run, exp_run, instr_count, m_count);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Literal checks and stimulus
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Advance one clock; inputs are then driven and outputs read 2 time units
  // after the rising edge, well away from both clock edges.
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  localparam logic [31:0] I_ADD  = 32'h192B0000; // ADD r2 <- r5, r6
  localparam logic [31:0] I_MUL  = 32'h789A0000; // MUL Ra=1, Rb=3, Rc=4
  localparam logic [31:0] I_DIV  = 32'h83C48000; // DIV Ra=7, Rb=8, Rc=9
  localparam logic [31:0] I_SUB  = 32'h27878000; // op 4, Ra=15, Rb=0, Rc=15
  localparam logic [31:0] I_NOP  = 32'hD0000000;
  localparam logic [31:0] I_HALT = 32'hD8000000;
  localparam logic [31:0] I_ILL  = 32'hF8000000; // opcode 0x1F

  initial begin
    clear = 1'b0;
    IR    = I_ADD;
    start = 1'b0;
    stop  = 1'b0;
    cyc(2);
    chk("reset_run", 64'(run), 64'd0);
    chk("reset_strobes", 64'(act), 64'd0);
    chk("reset_count", 64'(instr_count), 64'd0);
    clear = 1'b1;

    // ADD r2, r5, r6
    cyc(); chk("t0_fetch", 64'({run, PCout, MARin, IncPC, Read}), 64'b11110);
    cyc(); chk("t1_fetch", 64'({Read, MDRin, PCout}), 64'b110);
    cyc(); chk("t2_fetch", 64'({MDRout, IRin, MDRin}), 64'b110);
    cyc(); chk("add_t3", 64'({Rout, Yin}), 64'({16'h0020, 1'b1}));
    cyc(); chk("add_t4", 64'({Rout, ALUop, Zlowin}), 64'({16'h0040, 4'd3, 1'b1}));
    cyc(); chk("add_t5", 64'({Rin, Rout, Zlowout, instr_count}), 64'({16'h0004, 16'h0000, 1'b1, 4'd0}));
    cyc(); chk("add_retired", 64'(instr_count), 64'd1);

    // MUL Ra=1, Rb=3, Rc=4
    IR = I_MUL;
    cyc(3); chk("mul_t3", 64'({Rout, Yin}), 64'({16'h0008, 1'b1}));
    cyc();  chk("mul_t4", 64'({ALU_MUL, ALU_DIV, Zlowin, Zhighin, Rout}), 64'({4'b1011, 16'h0010}));
    cyc();  chk("mul_t5", 64'({LOin, Zlowout, instr_count}), 64'({2'b11, 4'd1}));
    cyc();  chk("mul_t6", 64'({HIin, Zhighout, instr_count}), 64'({2'b11, 4'd1}));
    cyc();  chk("mul_retired", 64'(instr_count), 64'd2);

    // DIV, NOP
    IR = I_DIV;
    cyc(4); chk("div_t4", 64'({ALU_DIV, ALU_MUL, Rout}), 64'({2'b10, 16'h0200}));
    cyc(3); chk("div_retired", 64'(instr_count), 64'd3);
    IR = I_NOP;
    cyc(4); chk("nop_retired", 64'({PCout, instr_count}), 64'({1'b1, 4'd4}));

    // Undefined opcode: pulse in T3 only, no retire
    IR = I_ILL;
    cyc(3); chk("ill_t3", 64'(illegal), 64'd1);
    cyc();  chk("ill_next_t0", 64'({illegal, PCout, instr_count}), 64'({1'b0, 1'b1, 4'd4}));

    // Register-index extremes
    IR = I_SUB;
    cyc(5); chk("sub_t5_rin", 64'(Rin), 64'h8000);
    cyc();  chk("sub_retired", 64'(instr_count), 64'd5);

    // Stop pulsed during T1 of an ADD: the ADD still writes back
    IR = I_ADD;
    cyc();  stop = 1'b1;
    cyc();  stop = 1'b0;
    cyc(3); chk("stop_add_t5", 64'(Rin), 64'h0004);
    cyc();  chk("stop_halted", 64'({run, PCout, instr_count}), 64'({2'b00, 4'd6}));
    cyc();  chk("halted_hold", 64'(run), 64'd0);

    // Start and stop together while halted: resume, no pending stop
    start = 1'b1; stop = 1'b1;
    cyc();  chk("resume_run", 64'({run, PCout, MARin}), 64'b111);
    start = 1'b0; stop = 1'b0;
    IR = I_NOP;
    cyc(4); chk("no_stop_latch", 64'({run, PCout, instr_count}), 64'({2'b11, 4'd7}));

    // HALT then start pulse
    IR = I_HALT;
    cyc(4); chk("halt_run", 64'({run, instr_count}), 64'({1'b0, 4'd8}));
    cyc();  start = 1'b1;
    cyc();  chk("halt_resume", 64'({run, PCout, MARin}), 64'b111);
    start = 1'b0;

    // Start while running is ignored; clear asserted mid-instruction in T4
    IR = I_ADD;
    cyc();  start = 1'b1;
    cyc();  start = 1'b0;
    cyc(2); chk("pre_clear_t4", 64'(Zlowin), 64'd1);
    clear = 1'b0;
    #1;
    chk("clear_async", 64'({run, act}), 64'd0);
    chk("clear_count", 64'(instr_count), 64'd0);
    cyc();  clear = 1'b1;
    cyc();  chk("restart_t0", 64'({run, PCout, MARin, IncPC}), 64'b1111);
    cyc(6); chk("restart_retired", 64'(instr_count), 64'd1);

    // Counter wrap: 14 NOPs reach the maximum, one more wraps to zero
    IR = I_NOP;
    cyc(14 * 4); chk("count_max", 64'(instr_count), 64'd15);
    cyc(4);      chk("count_wrap", 64'(instr_count), 64'd0);

    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
